// File: rtl/ins_slice_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ins_slice_pipe_pkg
//   Shared defaults and small types for the instruction slicer pipeline.
//   The *_DEF localparams are the default field layout of an instruction
//   word: opcode in the MSBs, then operand1, then operand2 in the LSBs.
// -----------------------------------------------------------------------------
package ins_slice_pipe_pkg;

  localparam int OPR_W_DEF  = 5;
  localparam int SRC_W_DEF  = 10;
  localparam int DST_W_DEF  = 10;
  localparam int DEPTH_DEF  = 2;
  localparam int IMM_EN_DEF = 1;

  // Per-cycle FIFO activity, built as {push, pop}.
  typedef enum logic [1:0] {
    OCC_IDLE = 2'b00,
    OCC_POP  = 2'b01,
    OCC_PUSH = 2'b10,
    OCC_BOTH = 2'b11
  } occ_e;

  // The occupancy counter needs one more bit than the pointers so that it can
  // represent "full" (count == DEPTH).
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ins_slice_pipe_fields.sv
// -----------------------------------------------------------------------------
// ins_slicer_fields
//   Pure combinational split of one instruction word into its fields.
// Ports
//   word      in   OPR_W+SRC_W+DST_W  instruction word
//   opr_code  out  OPR_W              opcode (word MSBs)
//   src_code  out  SRC_W              operand1 (middle field)
//   dst_code  out  DST_W              operand2 (word LSBs)
//   imm_code  out  SRC_W+DST_W        both operands merged as one immediate
//   is_imm    out  1                  opcode MSB when IMM_EN, else 0
// -----------------------------------------------------------------------------
module ins_slicer_fields
  import ins_slice_pipe_pkg::*;
#(
  parameter int OPR_W  = OPR_W_DEF,
  parameter int SRC_W  = SRC_W_DEF,
  parameter int DST_W  = DST_W_DEF,
  parameter int IMM_EN = IMM_EN_DEF
) (
  input  logic [OPR_W+SRC_W+DST_W-1:0] word,
  output logic [OPR_W-1:0]             opr_code,
  output logic [SRC_W-1:0]             src_code,
  output logic [DST_W-1:0]             dst_code,
  output logic [SRC_W+DST_W-1:0]       imm_code,
  output logic                         is_imm
);

  localparam int INS_W = OPR_W + SRC_W + DST_W;

  assign opr_code = word[INS_W-1 -: OPR_W];
  assign src_code = word[SRC_W+DST_W-1 : DST_W];
  assign dst_code = word[DST_W-1:0];
  assign imm_code = word[SRC_W+DST_W-1:0];
  assign is_imm   = (IMM_EN != 0) ? word[INS_W-1] : 1'b0;

endmodule

// File: rtl/ins_slice_pipe.sv
// -----------------------------------------------------------------------------
// ins_slice_pipe
//   Registered instruction slicer between instruction fetch and the decoders.
//   Fetched words are queued in a DEPTH-entry FIFO (valid/ready on both sides)
//   and the head entry is presented already split into its fields.
// Ports
//   clk          in   1                 system clock, rising edge
//   rst          in   1                 synchronous reset, active-high
//   flush        in   1                 discard all queued entries (branch/jump)
//   in_valid     in   1                 fetch word valid
//   in_ready     out  1                 FIFO can accept a word
//   instruction  in   INS_W             fetched word
//   out_valid    out  1                 head entry valid
//   out_ready    in   1                 decoder consumes head
//   opr_code     out  OPR_W             head opcode
//   src_code     out  SRC_W             head operand1
//   dst_code     out  DST_W             head operand2
//   imm_code     out  SRC_W+DST_W       head operands merged
//   is_imm       out  1                 head immediate-format flag
//   count        out  $clog2(DEPTH)+1   occupancy
// -----------------------------------------------------------------------------
module ins_slice_pipe
  import ins_slice_pipe_pkg::*;
#(
  parameter int OPR_W  = OPR_W_DEF,
  parameter int SRC_W  = SRC_W_DEF,
  parameter int DST_W  = DST_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IMM_EN = IMM_EN_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OPR_W+SRC_W+DST_W-1:0]  instruction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OPR_W-1:0]              opr_code,
  output logic [SRC_W-1:0]              src_code,
  output logic [DST_W-1:0]              dst_code,
  output logic [SRC_W+DST_W-1:0]        imm_code,
  output logic                          is_imm,
  output logic [cnt_w(DEPTH)-1:0]       count
);

  localparam int INS_W = OPR_W + SRC_W + DST_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [INS_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  occ_e             w_occ;
  logic [INS_W-1:0] w_head;

  // Both flags come straight from the registered count, so in_ready never
  // depends on out_ready in the same cycle and a word written this cycle is
  // only visible at the head from the next cycle on.
  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // A push in a flush cycle is dropped along with everything already queued.
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready;
  assign w_occ  = occ_e'({w_push, w_pop});

  // NOTE: the storage array carries no reset; validity is tracked entirely by
  // r_count, and leaving the array un-reset keeps it a plain RAM with no
  // per-entry reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= instruction;
    end
  end

  // Pointers wrap naturally at DEPTH (a power of two); r_count alone decides
  // full/empty, so equal pointers are never ambiguous.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case (w_occ)
        OCC_PUSH: r_count <= r_count + CNT_W'(1);
        OCC_POP:  r_count <= r_count - CNT_W'(1);
        default:  r_count <= r_count;
      endcase
    end
  end

  // The head is forced to zero while the FIFO is empty: fields read 0 after
  // reset and never expose uninitialised storage.
  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

  ins_slicer_fields #(
    .OPR_W  (OPR_W),
    .SRC_W  (SRC_W),
    .DST_W  (DST_W),
    .IMM_EN (IMM_EN)
  ) u_fields (
    .word     (w_head),
    .opr_code (opr_code),
    .src_code (src_code),
    .dst_code (dst_code),
    .imm_code (imm_code),
    .is_imm   (is_imm)
  );

endmodule

// File: tb/tb_ins_slice_pipe.sv
// -----------------------------------------------------------------------------
// tb_ins_slice_pipe
//   Two instances: A (DEPTH=2, IMM_EN=1) runs directed vectors, B (DEPTH=4,
//   IMM_EN=0) runs random valid/ready/flush traffic. Stimulus tasks push every
//   word the FIFO should accept into a per-instance expected queue and track
//   the expected occupancy; a negedge monitor per instance checks the flags
//   and count and compares the presented head against the queue front,
//   popping on each handshake.
// -----------------------------------------------------------------------------
module tb_ins_slice_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: DEPTH=2, IMM_EN=1 ----------------
  logic        a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [24:0] a_instr = '0;
  logic        a_in_ready, a_out_valid, a_is_imm;
  logic [4:0]  a_opr;
  logic [9:0]  a_src, a_dst;
  logic [19:0] a_imm;
  logic [1:0]  a_count;

  ins_slice_pipe #(.OPR_W(5), .SRC_W(10), .DST_W(10), .DEPTH(2), .IMM_EN(1)) u_dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .instruction(a_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .opr_code(a_opr), .src_code(a_src), .dst_code(a_dst), .imm_code(a_imm),
    .is_imm(a_is_imm), .count(a_count)
  );

  // ---------------- instance B: DEPTH=4, IMM_EN=0 ----------------
  logic        b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [24:0] b_instr = '0;
  logic        b_in_ready, b_out_valid, b_is_imm;
  logic [4:0]  b_opr;
  logic [9:0]  b_src, b_dst;
  logic [19:0] b_imm;
  logic [2:0]  b_count;

  ins_slice_pipe #(.OPR_W(5), .SRC_W(10), .DST_W(10), .DEPTH(4), .IMM_EN(0)) u_dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .instruction(b_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .opr_code(b_opr), .src_code(b_src), .dst_code(b_dst), .imm_code(b_imm),
    .is_imm(b_is_imm), .count(b_count)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [24:0] qa[$];
  logic [24:0] qb[$];
  int          a_m_cnt = 0, a_exp_cnt = 0;
  int          b_m_cnt = 0, b_exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of A inputs and advance the expected-occupancy model.
  task automatic apply_a(input logic v, input logic [24:0] w, input logic r, input logic f);
    bit acc, pop;
    a_in_valid = v; a_instr = w; a_out_ready = r; a_flush = f;
    a_exp_cnt = a_m_cnt;
    if (f) begin
      qa.delete();
      a_m_cnt = 0;
    end else begin
      acc = v && (a_m_cnt < 2);
      pop = (a_m_cnt != 0) && r;
      if (acc) qa.push_back(w);
      a_m_cnt = a_m_cnt + int'(acc) - int'(pop);
    end
  endtask

  task automatic apply_b(input logic v, input logic [24:0] w, input logic r, input logic f);
    bit acc, pop;
    b_in_valid = v; b_instr = w; b_out_ready = r; b_flush = f;
    b_exp_cnt = b_m_cnt;
    if (f) begin
      qb.delete();
      b_m_cnt = 0;
    end else begin
      acc = v && (b_m_cnt < 4);
      pop = (b_m_cnt != 0) && r;
      if (acc) qb.push_back(w);
      b_m_cnt = b_m_cnt + int'(acc) - int'(pop);
    end
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    apply_a(1'b0, '0, 1'b0, 1'b0);
    qa.delete();
    a_m_cnt = 0;
    step();
    step();
    a_rst = 1'b0;
    a_exp_cnt = 0;
  endtask

  task automatic reset_b();
    b_rst = 1'b1;
    apply_b(1'b0, '0, 1'b0, 1'b0);
    qb.delete();
    b_m_cnt = 0;
    step();
    step();
    b_rst = 1'b0;
    b_exp_cnt = 0;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [24:0] h;
    if (!a_rst && !a_flush) begin
      check("a_count",     a_count,     a_exp_cnt);
      check("a_in_ready",  a_in_ready,  a_exp_cnt < 2);
      check("a_out_valid", a_out_valid, a_exp_cnt != 0);
      if (a_out_valid) begin
        check("a_head_expected", qa.size() != 0, 1'b1);
        if (qa.size() != 0) begin
          h = qa[0];
          check("a_opr",    a_opr,    h[24:20]);
          check("a_src",    a_src,    h[19:10]);
          check("a_dst",    a_dst,    h[9:0]);
          check("a_imm",    a_imm,    h[19:0]);
          check("a_is_imm", a_is_imm, h[24]);
          if (a_out_ready) void'(qa.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [24:0] h;
    if (!b_rst && !b_flush) begin
      check("b_count",     b_count,     b_exp_cnt);
      check("b_in_ready",  b_in_ready,  b_exp_cnt < 4);
      check("b_out_valid", b_out_valid, b_exp_cnt != 0);
      if (b_out_valid) begin
        check("b_head_expected", qb.size() != 0, 1'b1);
        if (qb.size() != 0) begin
          h = qb[0];
          check("b_opr",    b_opr,    h[24:20]);
          check("b_src",    b_src,    h[19:10]);
          check("b_dst",    b_dst,    h[9:0]);
          check("b_imm",    b_imm,    h[19:0]);
          check("b_is_imm", b_is_imm, 1'b0);
          if (b_out_ready) void'(qb.pop_front());
        end
      end
    end
  end

  // ---------------- directed vectors on A ----------------
  task automatic run_a();
    logic [24:0] w0, w1, w2, w3, w4, w5, w6, w7, w8, w9;
    w0 = {5'h1A, 10'h2A5, 10'h0F3};
    w1 = {5'h05, 10'h111, 10'h222};
    w2 = {5'h13, 10'h333, 10'h044};
    w3 = {5'h1F, 10'h3FF, 10'h001};
    w4 = {5'h01, 10'h010, 10'h020};
    w5 = {5'h02, 10'h030, 10'h040};
    w6 = {5'h1E, 10'h0EE, 10'h0EE};
    w7 = {5'h07, 10'h077, 10'h377};
    w8 = {5'h08, 10'h088, 10'h188};
    w9 = {5'h09, 10'h099, 10'h199};

    // Reset state.
    reset_a();
    apply_a(1'b0, '0, 1'b0, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_in_ready",  a_in_ready,  1'b1);
    check("rst_count",     a_count,     2'd0);
    check("rst_opr",       a_opr,       5'h00);
    check("rst_src",       a_src,       10'h000);
    check("rst_dst",       a_dst,       10'h000);
    check("rst_is_imm",    a_is_imm,    1'b0);
    step();

    // Single word: visible one cycle after the push, fields hand-sliced.
    apply_a(1'b1, w0, 1'b0, 1'b0);
    #2 check("single_not_fallthrough", a_out_valid, 1'b0);
    step();
    apply_a(1'b0, '0, 1'b0, 1'b0);
    #2;
    check("single_out_valid", a_out_valid, 1'b1);
    check("single_opr",       a_opr,       5'h1A);
    check("single_src",       a_src,       10'h2A5);
    check("single_dst",       a_dst,       10'h0F3);
    check("single_imm",       a_imm,       20'hA94F3);
    check("single_is_imm",    a_is_imm,    1'b1);
    step();
    apply_a(1'b0, '0, 1'b1, 1'b0);
    step();

    // Fill: third word is held off while full, head stays on w1.
    apply_a(1'b1, w1, 1'b0, 1'b0); step();
    apply_a(1'b1, w2, 1'b0, 1'b0); step();
    apply_a(1'b1, w3, 1'b0, 1'b0);
    #2;
    check("fill_count",    a_count,    2'd2);
    check("fill_in_ready", a_in_ready, 1'b0);
    check("fill_head_opr", a_opr,      5'h05);
    check("fill_head_src", a_src,      10'h111);
    step();
    apply_a(1'b1, w3, 1'b0, 1'b0); step();
    // Full + pop: w3 still refused this cycle, count drops to 1.
    apply_a(1'b1, w3, 1'b1, 1'b0); step();
    apply_a(1'b1, w3, 1'b1, 1'b0);
    #2;
    check("fullpop_count", a_count, 2'd1);
    check("fullpop_head",  a_opr,   5'h13);
    step();
    apply_a(1'b0, '0, 1'b1, 1'b0);
    #2 check("fill_last_head", a_opr, 5'h1F);
    step();
    apply_a(1'b0, '0, 1'b0, 1'b0); step();

    // Streaming: one word per cycle, occupancy stays at 1.
    for (int i = 0; i < 16; i++) begin
      apply_a(1'b1, 25'h0100000 + 25'(i), 1'b1, 1'b0);
      if (i > 0) begin
        #2 check("stream_count", a_count, 2'd1);
      end
      step();
    end
    apply_a(1'b0, '0, 1'b1, 1'b0); step();
    apply_a(1'b0, '0, 1'b0, 1'b0); step();

    // Flush with two queued words and a concurrent push.
    apply_a(1'b1, w4, 1'b0, 1'b0); step();
    apply_a(1'b1, w5, 1'b0, 1'b0); step();
    apply_a(1'b1, w6, 1'b0, 1'b1);
    #2 check("preflush_count", a_count, 2'd2);
    step();
    apply_a(1'b0, '0, 1'b0, 1'b0);
    #2;
    check("flush_count",     a_count,     2'd0);
    check("flush_out_valid", a_out_valid, 1'b0);
    check("flush_in_ready",  a_in_ready,  1'b1);
    step();
    apply_a(1'b1, w7, 1'b0, 1'b0); step();
    apply_a(1'b0, '0, 1'b1, 1'b0);
    #2 check("postflush_head", a_opr, 5'h07);
    step();
    apply_a(1'b0, '0, 1'b0, 1'b0); step();

    // Reset mid-stream drops everything.
    apply_a(1'b1, w8, 1'b0, 1'b0); step();
    apply_a(1'b1, w9, 1'b0, 1'b0); step();
    reset_a();
    apply_a(1'b0, '0, 1'b1, 1'b0);
    check("midrst_count",     a_count,     2'd0);
    check("midrst_out_valid", a_out_valid, 1'b0);
    step();
    apply_a(1'b0, '0, 1'b0, 1'b0); step();
  endtask

  // ---------------- random traffic on B ----------------
  task automatic run_b();
    logic v, r, f;
    reset_b();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 99) == 0);
      apply_b(v, 25'($urandom), r, f);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      apply_b(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    check("b_drained", qb.size(), 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    a_rst = 1'b1;
    b_rst = 1'b1;
    check("a_drained", qa.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
